// File: rtl/song_pattern_writer_if.sv
// Bundles the start/end levels from the player side and the song word and strobes toward the game module.
interface song_pattern_writer_if;
  logic        start_req;
  logic        game_end;
  logic [31:0] data_out;
  logic        write_enable;
  logic        game_start;
  logic        busy;
  logic [2:0]  state_out;
  logic [3:0]  note_count_out;

  modport master (
    input  start_req, game_end,
    output data_out, write_enable, game_start, busy, state_out, note_count_out
  );

  modport slave (
    output start_req, game_end,
    input  data_out, write_enable, game_start, busy, state_out, note_count_out
  );
endinterface

// File: rtl/song_pattern_writer.sv
// Builds an 8-note song from a free-running LFSR, writes it to the game module and fires game_start
// after a programmable delay; rearms when the game reports its end.
module song_pattern_writer #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned START_DELAY = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  song_pattern_writer_if.master bus
);

  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DELAY_W = 20;

  localparam logic [LFSR_W-1:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [LFSR_W-1:0] TAPS      = 16'hB400;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GEN     = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] START   = 3'd4;
  localparam logic [2:0] PLAYING = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic               start_q, end_q;
  logic [DATA_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               we_q, we_d;
  logic               gs_q, gs_d;
  logic               busy_q;

  logic       start_rise, end_rise;
  logic [2:0] cand, prev_idx, prev_note;

  // Galois step, taps 16,14,13,11
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
  end

  always_comb begin
    start_rise = bus.start_req & ~start_q;
    end_rise   = bus.game_end & ~end_q;
    cand       = lfsr_q[2:0];
    prev_idx   = cnt_q[2:0] - 3'd1;
    prev_note  = buf_q[{prev_idx, 2'b00} +: 3];
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    data_d  = data_q;
    we_d    = 1'b0;
    gs_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = GEN;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      GEN: begin
        // A candidate equal to the previous note is dropped so no two adjacent notes repeat
        if (!((cnt_q != 4'd0) && (cand == prev_note))) begin
          buf_d[{cnt_q[2:0], 2'b00} +: 4] = {1'b0, cand};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            data_d  = buf_d;
            we_d    = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        delay_d = DELAY_W'(START_DELAY);
        state_d = WAIT;
      end
      WAIT: begin
        delay_d = delay_q - 20'd1;
        if (delay_q == 20'd1) begin
          gs_d    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        state_d = PLAYING;
      end
      PLAYING: begin
        if (end_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_INIT;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      delay_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      gs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      start_q <= bus.start_req;
      end_q   <= bus.game_end;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      data_q  <= data_d;
      we_q    <= we_d;
      gs_q    <= gs_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.data_out       = data_q;
  assign bus.write_enable   = we_q;
  assign bus.game_start     = gs_q;
  assign bus.busy           = busy_q;
  assign bus.state_out      = state_q;
  assign bus.note_count_out = cnt_q;

endmodule

// File: doc/song_pattern_writer.md
Name: song_pattern_writer

Overview:
- Generates the 8-note song word consumed by the game module: data word, one-cycle `write_enable` pulse, then a one-cycle `game_start` pulse.
- Sits between the start push-button and the game module's `data_in` / `write_enable` / `game_start` inputs.
- Returns to idle when the game module raises `game_end`, ready for a new round.
- Notes come from a free-running LFSR, so the press timing randomises the song.

Parameters:
- SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- START_DELAY, 500000: cycles between the end of `write_enable` and `game_start`; legal range 1..2^20-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start_req  in  1  start button level, already synchronised/debounced
- game_end  in  1  game-over level from game module
- data_out  out  32  song word; nibble i = {1'b0, note_i[2:0]}, note 0 in bits [3:0]
- write_enable  out  1  one-cycle strobe, data_out valid
- game_start  out  1  one-cycle strobe
- busy  out  1  high in every state except IDLE
- state_out  out  3  current state encoding, for debug LEDs
- note_count_out  out  4  notes generated so far, 0..8

Behaviour:
- All outputs are registered and glitch-free. The game module edge-samples the strobes.
- Reset (reset=0), asynchronous:
  - data_out=0, write_enable=0, game_start=0, busy=0, note_count=0, state=IDLE.
  - lfsr=SEED; start_q=0, end_q=0.
- LFSR (16-bit Galois, runs every clock in every state, including GEN):
  - lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0).
- Edge detect:
  - start_rise = start_req & ~start_q; end_rise = game_end & ~end_q.
  - start_q and end_q are updated every clock.
- State encodings: IDLE=0, GEN=1, WRITE=2, WAIT=3, START=4, PLAYING=5.
- IDLE:
  - On start_rise: go to GEN, clear the internal buffer and note_count.
  - game_end is ignored.
- GEN (one candidate per clock):
  - cand = lfsr[2:0] (value before this edge's step).
  - If note_count > 0 and cand equals the previous note: skip; count and buffer are unchanged.
  - Otherwise: write {1'b0,cand} into buffer nibble note_count and increment note_count.
  - On the edge that stores the 8th note: data_out <= full buffer, write_enable <= 1, state <= WRITE.
  - start_req and game_end are ignored.
- WRITE (exactly one cycle):
  - Next edge: write_enable <= 0, load the delay counter with START_DELAY, go to WAIT.
- WAIT:
  - Counter decrements each clock.
  - On the edge where it reaches 0: game_start <= 1, go to START.
- START (exactly one cycle):
  - Next edge: game_start <= 0, go to PLAYING.
- PLAYING:
  - On end_rise: go to IDLE; data_out holds its value.
  - start_rise is ignored.
  - If game_end is already high on entry, no rising edge is seen and the block stays until game_end falls and rises again.
- data_out changes only on the edge that raises write_enable; it is stable at every other time.
- Latency, start_rise to write_enable: at least 9 clocks (1 + 8 notes + skips).
- Latency, write_enable rise to game_start rise: START_DELAY+1 clocks.
- Reset asserted in any state returns everything to the reset values immediately. A partial song is never written.

Test Plan:
- Reset then release; start_req=1 at the first edge -> GEN samples E270,7138(skip),389C,1C4E,0E27,B313,ED89,C2C4,6162 -> data_out=32'h24137640, write_enable high for exactly 1 cycle, note_count_out=8.
- START_DELAY=4, same stimulus -> game_start high for exactly 1 cycle, rising 5 clocks after write_enable rises; state_out sequence 1,2,3,4,5.
- In PLAYING, toggle start_req -> no new write_enable. Raise game_end -> IDLE, busy=0, data_out still 32'h24137640.
- Hold start_req high continuously through a whole round -> only one song is generated; a second song requires start_req to fall and rise.
- Assert reset mid-GEN after 4 notes -> all outputs 0 asynchronously, lfsr=SEED; no write_enable ever issued for the partial song.
- Random press timing, 1000 rounds -> no adjacent equal notes, every bit 3 of each nibble is 0, every song matches the LFSR reference model.
